butterfly_fft_sched: RTL and testbench
======================================

// Module: butterfly_fft_sched
// PURPOSE
//  Sequencer for an in-place radix-2 DIT FFT built around the combinational butterfly_sum datapath.
//  - Walks all LOG2N stages, N/2 butterflies per stage.
//  - For each butterfly, issues one dual-port sample-RAM read (A,B) and one twiddle-ROM read, then the in-place write-back of o_A/o_B.
//  - Input samples are preloaded into RAM in bit-reversed order by the loader.
// PARAMETERS
//  LOG2N    3    log2 of FFT length N; legal range 2..10
//  ADDR_W   LOG2N (localparam)    sample RAM address width
//  TW_W     LOG2N-1 (localparam)  twiddle ROM address width (N/2 entries)
// PORTS
//  i_clk       in   1       clock; all logic on rising edge
//  i_rst       in   1       synchronous, active-high reset
//  i_start     in   1       start request; sampled only in IDLE
//  i_hold      in   1       memory arbiter hold; blocks issuing a read
//  o_busy      out  1       high in RD and WR states
//  o_done      out  1       one-cycle completion pulse
//  o_rd_en     out  1       sample RAM and twiddle ROM read strobe
//  o_wr_en     out  1       sample RAM write strobe (both ports)
//  o_addr_A    out  ADDR_W  RAM port A address (read and write)
//  o_addr_B    out  ADDR_W  RAM port B address (read and write)
//  o_tw_addr   out  TW_W    twiddle ROM address
//  o_stage     out  ADDR_W  current stage index s, 0..LOG2N-1
// BEHAVIOUR
//  Reset
//  - Any cycle with i_rst=1 forces IDLE and clears s, k and every output to 0.
//  - No write is issued in that cycle.
//  - Reset mid-run abandons the transform; RAM contents are then undefined.
//  Memory timing
//  - RAM and ROM read latency is 1 cycle; data is valid in the cycle after o_rd_en.
//  States
//  - IDLE: i_start=1 -> RD with s=0, k=0; otherwise stay.
//  - RD:
//    - i_hold=1: o_rd_en=0, stay in RD, addresses held.
//    - i_hold=0: o_rd_en=1, -> WR.
//  - WR:
//    - o_wr_en=1 for exactly one cycle; i_hold is ignored.
//    - The RAM writes butterfly_sum o_A/o_B back to o_addr_A/o_addr_B.
//    - Then:
//      - k<N/2-1: k+1, -> RD.
//      - k=N/2-1 and s<LOG2N-1: k=0, s+1, -> RD.
//      - otherwise: -> DONE.
//  - DONE: o_done=1 for one cycle, -> IDLE unconditionally.
//  - i_start is ignored outside IDLE; there is no queuing.
//  Address arithmetic (unsigned)
//  - span = 1<<s; grp = k>>s; pos = k & (span-1).
//  - o_addr_A = (grp<<(s+1)) | pos; o_addr_B = o_addr_A + span.
//  - o_tw_addr = pos << (LOG2N-1-s).
//  - All three are registered: they update on entry to RD and stay stable through RD and WR of the same butterfly.
//  - No address ever wraps; o_addr_B <= N-1 always.
//  Latency
//  - With i_hold=0 throughout, o_done is high exactly LOG2N*N+1 cycles after the cycle in which i_start was sampled (N=8: 25).
//  - Each RD-state cycle with i_hold=1 adds one cycle.
//  Other rules
//  - o_busy=0 in IDLE and DONE.
//  - o_rd_en and o_wr_en are never high in the same cycle.
// TESTING
//  - T1 (LOG2N=3): i_start pulse, i_hold=0 -> stage 0 (A,B,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0).
//  - T1 cont.: stage 1 = (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage 2 = (0,4,0),(1,5,1),(2,6,2),(3,7,3); o_done at cycle 25.
//  - T2: i_hold=1 for 3 cycles in the first RD -> o_rd_en stays 0, addresses hold at (0,1,0), o_done at cycle 28.
//  - T3: i_start=1 on every cycle -> exactly one run, o_done once; the run restarts only after DONE->IDLE.
//  - T4: i_rst=1 during a WR of stage 1 -> o_wr_en=0 in that cycle, all outputs 0 next cycle; a new i_start runs a full 25-cycle transform.
//  - T5: RAM model + butterfly_sum; load bit-reversed impulse x[0]=1<<6, rest 0, twiddles (1<<6,0)... -> all 8 bins equal 1<<6 real, 0 imag.
//  - T6: LOG2N=2 -> 4 butterflies, (0,1,0),(2,3,0),(0,2,0),(1,3,1); o_done at cycle 9.

Source files
------------

// File: rtl/butterfly_fft_sched.sv
// butterfly_fft_sched
// Address and strobe sequencer for an in-place radix-2 decimation-in-time FFT.
// It walks LOG2N stages with N/2 butterflies in each stage. For every butterfly
// it issues one read cycle (dual-port sample RAM A/B plus twiddle ROM) and then
// one write cycle, in which the butterfly results go back to the same two
// addresses.
//
// Ports
//   i_clk      clock; all logic is on the rising edge
//   i_rst      synchronous, active-high reset
//   i_start    start request; only looked at in IDLE
//   i_hold     memory arbiter hold; stalls the read cycle
//   o_busy     high in the RD and WR states
//   o_done     one-cycle completion pulse
//   o_rd_en    read strobe for the sample RAM and the twiddle ROM
//   o_wr_en    write strobe for the sample RAM (both ports)
//   o_addr_A   RAM port A address (read and write)
//   o_addr_B   RAM port B address (read and write)
//   o_tw_addr  twiddle ROM address
//   o_stage    current stage index
module butterfly_fft_sched #(
  parameter  int LOG2N  = 3,
  localparam int ADDR_W = LOG2N,
  localparam int TW_W   = LOG2N - 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_addr_A,
  output logic [ADDR_W-1:0] o_addr_B,
  output logic [TW_W-1:0]   o_tw_addr,
  output logic [ADDR_W-1:0] o_stage
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;

  localparam logic [TW_W-1:0]   K_LAST = TW_W'((1 << LOG2N) / 2 - 1);
  localparam logic [ADDR_W-1:0] S_LAST = ADDR_W'(LOG2N - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] s_q, s_d;
  logic [TW_W-1:0]   k_q, k_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [TW_W-1:0]   tw_q, tw_d;

  logic [ADDR_W-1:0] k_ext, span, grp, pos, calc_a, calc_b;
  logic [TW_W-1:0]   calc_tw;
  logic              load_addr;

  // Sequencing: stage/butterfly counters and the state register.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RD;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ST_RD: begin
        if (!i_hold) state_d = ST_WR;
      end
      ST_WR: begin
        if (k_q != K_LAST) begin
          k_d     = k_q + TW_W'(1);
          state_d = ST_RD;
        end else if (s_q != S_LAST) begin
          k_d     = '0;
          s_d     = s_q + ADDR_W'(1);
          state_d = ST_RD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Butterfly addresses for the (s, k) that the next cycle will work on.
  // Butterfly k of stage s sits in group k>>s; its two legs are span apart,
  // and groups are 2*span apart.
  always_comb begin
    k_ext   = ADDR_W'(k_d);
    span    = ADDR_W'(1) << s_d;
    grp     = k_ext >> s_d;
    pos     = k_ext & (span - ADDR_W'(1));
    calc_a  = (grp << (s_d + ADDR_W'(1))) | pos;
    calc_b  = calc_a + span;
    calc_tw = TW_W'(pos << (S_LAST - s_d));
  end

  // The address registers load only when RD is entered, so they stay
  // stable through any hold cycles and through the matching write.
  always_comb begin
    load_addr = (state_d == ST_RD) && (state_q != ST_RD);
    addr_a_d  = load_addr ? calc_a  : addr_a_q;
    addr_b_d  = load_addr ? calc_b  : addr_b_q;
    tw_d      = load_addr ? calc_tw : tw_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      k_q      <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      k_q      <= k_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
    end
  end

  // Strobes are masked by reset in the reset cycle itself, so an
  // interrupted write never reaches the RAM.
  assign o_busy    = (state_q == ST_RD) || (state_q == ST_WR);
  assign o_rd_en   = (state_q == ST_RD) && !i_hold && !i_rst;
  assign o_wr_en   = (state_q == ST_WR) && !i_rst;
  assign o_done    = (state_q == ST_DONE) && !i_rst;
  assign o_addr_A  = addr_a_q;
  assign o_addr_B  = addr_b_q;
  assign o_tw_addr = tw_q;
  assign o_stage   = s_q;

endmodule

// File: tb/tb_butterfly_fft_sched.sv
// Testbench for butterfly_fft_sched: an N=8 instance checked against a
// transaction-level model on every cycle, a small sample RAM/twiddle ROM with
// a butterfly model for an impulse transform, and an N=4 instance checked
// against hand-written butterfly tables.
module tb_butterfly_fft_sched;

  localparam int N  = 8;
  localparam int NB = 12;  // butterflies per N=8 transform

  logic       clk;
  logic       rst, start, hold, start2;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] addr_a, addr_b, stage;
  logic [1:0] tw_addr;
  logic       busy2, done2, rd_en2, wr_en2;
  logic [1:0] addr_a2, addr_b2, stage2;
  logic [0:0] tw_addr2;

  butterfly_fft_sched #(.LOG2N(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_hold(hold),
    .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_wr_en(wr_en),
    .o_addr_A(addr_a), .o_addr_B(addr_b), .o_tw_addr(tw_addr), .o_stage(stage)
  );

  butterfly_fft_sched #(.LOG2N(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_hold(1'b0),
    .o_busy(busy2), .o_done(done2), .o_rd_en(rd_en2), .o_wr_en(wr_en2),
    .o_addr_A(addr_a2), .o_addr_B(addr_b2), .o_tw_addr(tw_addr2), .o_stage(stage2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  // Expected butterfly list, built as "for each stage, for each group of
  // 2*span samples, pair sample j with sample j+span".
  int exp_a[$], exp_b[$], exp_tw[$], exp_s[$];
  int m_mode = 0;          // 0 idle, 1 running, 2 done
  int m_idx = 0;
  bit m_wr = 1'b0;
  bit m_after_rst = 1'b0;
  int start_cyc = 0, last_lat = 0, done_cnt = 0;
  int start2_cyc = 0, lat2 = 0, done2_cnt = 0;
  int wlog[$], wlog2[$];

  initial begin
    for (int s = 0; s < 3; s++) begin
      int span;
      span = 1 << s;
      for (int g = 0; g < N; g += 2 * span)
        for (int j = 0; j < span; j++) begin
          exp_a.push_back(g + j);
          exp_b.push_back(g + j + span);
          exp_tw.push_back(j * (N / (2 * span)));
          exp_s.push_back(s);
        end
    end
  end

  // Single compare process: check the current cycle, then advance the model
  // with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        chk("wr_en_in_reset", int'(wr_en), 0);
        chk("rd_en_in_reset", int'(rd_en), 0);
      end else begin
        case (m_mode)
          0: begin
            chk("idle_busy", int'(busy), 0);
            chk("idle_rd_en", int'(rd_en), 0);
            chk("idle_wr_en", int'(wr_en), 0);
            chk("idle_done", int'(done), 0);
            if (m_after_rst) begin
              chk("rst_addr_A", int'(addr_a), 0);
              chk("rst_addr_B", int'(addr_b), 0);
              chk("rst_tw_addr", int'(tw_addr), 0);
              chk("rst_stage", int'(stage), 0);
            end
          end
          1: begin
            chk("run_busy", int'(busy), 1);
            chk("run_done", int'(done), 0);
            chk("run_rd_en", int'(rd_en), (m_wr || hold) ? 0 : 1);
            chk("run_wr_en", int'(wr_en), m_wr ? 1 : 0);
            chk("addr_A", int'(addr_a), exp_a[m_idx]);
            chk("addr_B", int'(addr_b), exp_b[m_idx]);
            chk("tw_addr", int'(tw_addr), exp_tw[m_idx]);
            chk("stage", int'(stage), exp_s[m_idx]);
          end
          default: begin
            chk("done_pulse", int'(done), 1);
            chk("done_busy", int'(busy), 0);
            chk("done_wr_en", int'(wr_en), 0);
          end
        endcase
      end
      chk("rd_wr_exclusive", int'(rd_en & wr_en), 0);
    end

    if (wr_en) begin
      wlog.push_back(int'(addr_a) * 100 + int'(addr_b) * 10 + int'(tw_addr));
      $display("n8 write s=%0d A=%0d B=%0d tw=%0d", stage, addr_a, addr_b, tw_addr);
    end
    if (done) begin
      done_cnt++;
      last_lat = cyc - start_cyc;
      $display("n8 done latency=%0d", last_lat);
    end
    if (wr_en2) begin
      wlog2.push_back(int'(addr_a2) * 100 + int'(addr_b2) * 10 + int'(tw_addr2));
      $display("n4 write s=%0d A=%0d B=%0d tw=%0d", stage2, addr_a2, addr_b2, tw_addr2);
    end
    if (done2) begin
      done2_cnt++;
      lat2 = cyc - start2_cyc;
      $display("n4 done latency=%0d", lat2);
    end
    if (!rst && start2 && !busy2 && !done2) start2_cyc = cyc;

    m_after_rst = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_after_rst = 1'b1;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_mode = 1; m_idx = 0; m_wr = 1'b0; start_cyc = cyc;
        end
        1: begin
          if (!m_wr) begin
            if (!hold) m_wr = 1'b1;
          end else if (m_idx == NB - 1) begin
            m_mode = 2;
          end else begin
            m_idx++; m_wr = 1'b0;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  // ---------------- sample RAM, twiddle ROM, butterfly ----------------
  int ram_re[N], ram_im[N];
  int rd_are = 0, rd_aim = 0, rd_bre = 0, rd_bim = 0, rd_wre = 0, rd_wim = 0;
  bit ram_load = 1'b0;

  function automatic int rom_re(input int i);
    case (i)
      0: return 64;  1: return 45;  2: return 0;  default: return -45;
    endcase
  endfunction
  function automatic int rom_im(input int i);
    case (i)
      0: return 0;  1: return -45;  2: return -64;  default: return -45;
    endcase
  endfunction
  function automatic int bitrev3(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  // Q6 product W*B, then A+WB to port A and A-WB to port B.
  int t_re, t_im;
  always @* begin
    t_re = (rd_bre * rd_wre - rd_bim * rd_wim) >>> 6;
    t_im = (rd_bre * rd_wim + rd_bim * rd_wre) >>> 6;
  end

  always @(posedge clk) begin
    if (ram_load) begin
      for (int n = 0; n < N; n++) begin
        ram_re[bitrev3(n)] <= (n == 0) ? 64 : 0;
        ram_im[bitrev3(n)] <= 0;
      end
    end else begin
      if (rd_en) begin
        rd_are <= ram_re[addr_a]; rd_aim <= ram_im[addr_a];
        rd_bre <= ram_re[addr_b]; rd_bim <= ram_im[addr_b];
        rd_wre <= rom_re(int'(tw_addr)); rd_wim <= rom_im(int'(tw_addr));
      end
      if (wr_en) begin
        ram_re[addr_a] <= rd_are + t_re; ram_im[addr_a] <= rd_aim + t_im;
        ram_re[addr_b] <= rd_are - t_re; ram_im[addr_b] <= rd_aim - t_im;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(input string name, input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      step(1);
      n++;
    end
    chk(name, int'(done_cnt != d0), 1);
  endtask

  int t1_tab[NB] = '{10, 230, 450, 670, 20, 132, 460, 572, 40, 151, 262, 373};
  int t6_tab[4]  = '{10, 230, 20, 131};

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; start2 = 1'b0;
    step(2);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_stage", int'(stage), 0);

    // T1 + T5: plain run on a bit-reversed impulse
    ram_load = 1'b1; step(1); ram_load = 1'b0;
    wlog.delete();
    start = 1'b1; step(1); start = 1'b0;
    wait_done("t1_done_timeout", 100);
    chk("t1_latency", last_lat, 25);
    chk("t1_write_count", wlog.size(), NB);
    for (int i = 0; i < NB; i++)
      chk("t1_butterfly", (i < wlog.size()) ? wlog[i] : -1, t1_tab[i]);
    for (int i = 0; i < N; i++) begin
      chk("t5_bin_re", ram_re[i], 64);
      chk("t5_bin_im", ram_im[i], 0);
    end

    // T2: three hold cycles in the first read
    start = 1'b1; step(1); start = 1'b0;
    hold = 1'b1; step(1);
    chk("t2_hold_rd_en", int'(rd_en), 0);
    chk("t2_hold_addr_B", int'(addr_b), 1);
    step(2); hold = 1'b0;
    wait_done("t2_done_timeout", 100);
    chk("t2_latency", last_lat, 28);

    // T3: start held high throughout
    start = 1'b1; step(1);
    begin
      int d0;
      d0 = done_cnt;
      step(30);
      chk("t3_single_done", done_cnt - d0, 1);
    end
    chk("t3_restarted", int'(busy), 1);
    start = 1'b0;
    wait_done("t3_done_timeout", 100);
    chk("t3_restart_latency", last_lat, 25);

    // T4: reset during the first write of stage 1, then a full run
    start = 1'b1; step(1); start = 1'b0;
    step(9);
    chk("t4_pre_wr_en", int'(wr_en), 1);
    chk("t4_pre_stage", int'(stage), 1);
    rst = 1'b1; #1;
    chk("t4_wr_masked", int'(wr_en), 0);
    step(1); rst = 1'b0;
    chk("t4_busy_cleared", int'(busy), 0);
    chk("t4_addr_A_cleared", int'(addr_a), 0);
    chk("t4_addr_B_cleared", int'(addr_b), 0);
    chk("t4_tw_cleared", int'(tw_addr), 0);
    chk("t4_stage_cleared", int'(stage), 0);
    start = 1'b1; step(1); start = 1'b0;
    wait_done("t4_done_timeout", 100);
    chk("t4_latency", last_lat, 25);

    // T6: N=4 instance
    wlog2.delete();
    start2 = 1'b1; step(1); start2 = 1'b0;
    begin
      int d0, n;
      d0 = done2_cnt;
      n = 0;
      while (done2_cnt == d0 && n < 50) begin
        step(1);
        n++;
      end
      chk("t6_done_timeout", int'(done2_cnt != d0), 1);
    end
    chk("t6_latency", lat2, 9);
    chk("t6_write_count", wlog2.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t6_butterfly", (i < wlog2.size()) ? wlog2[i] : -1, t6_tab[i]);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
